// File: rtl/mul_div_unit.sv
// Sequential signed multiply (radix-4 Booth, 16 cycles) / divide (non-restoring, 32 cycles).
// Define MULDIV_DIV_EN to build the divider; without it op=1 completes at once with zero results.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] z_low,
  output logic [31:0] z_high,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_reg;
  logic [4:0]  cnt_reg;
  logic [63:0] prod_reg;
  logic [63:0] mcand_reg;
  logic [32:0] mplr_reg;
  logic [63:0] pp;
  logic [63:0] prod_next;

  // Booth digit from the low three multiplier bits; the multiplicand walks left two bits per step.
  always_comb begin
    pp = '0;
    case (mplr_reg[2:0])
      3'b001, 3'b010: pp = mcand_reg;
      3'b011:         pp = mcand_reg << 1;
      3'b100:         pp = -(mcand_reg << 1);
      3'b101, 3'b110: pp = -mcand_reg;
      default:        pp = '0;
    endcase
    prod_next = prod_reg + pp;
  end

`ifdef MULDIV_DIV_EN
  logic [33:0] rem_reg;
  logic [33:0] rem_shift;
  logic [33:0] rem_step;
  logic [31:0] rem_fix;
  logic [31:0] quo_reg;
  logic [31:0] quo_step;
  logic [31:0] dvsr_reg;
  logic [31:0] q_out;
  logic [31:0] r_out;
  logic        neg_q_reg;
  logic        neg_r_reg;

  // Remainder sign picks add or subtract; the final negative remainder is corrected once.
  always_comb begin
    rem_shift = {rem_reg[32:0], quo_reg[31]};
    rem_step  = rem_reg[33] ? rem_shift + {2'b00, dvsr_reg} : rem_shift - {2'b00, dvsr_reg};
    quo_step  = {quo_reg[30:0], ~rem_step[33]};
    rem_fix   = rem_step[31:0] + (rem_step[33] ? dvsr_reg : 32'd0);
    q_out     = neg_q_reg ? -quo_step : quo_step;
    r_out     = neg_r_reg ? -rem_fix : rem_fix;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      prod_reg    <= '0;
      mcand_reg   <= '0;
      mplr_reg    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      z_low       <= '0;
      z_high      <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvsr_reg    <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          if (start) begin
            cnt_reg <= '0;
            if (!op) begin
              state_reg <= MUL;
              busy      <= 1'b1;
              prod_reg  <= '0;
              mcand_reg <= {{32{a[31]}}, a};
              mplr_reg  <= {b, 1'b0};
            end else begin
`ifdef MULDIV_DIV_EN
              if (b == 32'd0) begin
                state_reg   <= DONE;
                done        <= 1'b1;
                z_low       <= '1;
                z_high      <= a;
                div_by_zero <= 1'b1;
              end else begin
                state_reg <= DIV;
                busy      <= 1'b1;
                rem_reg   <= '0;
                quo_reg   <= a[31] ? -a : a;
                dvsr_reg  <= b[31] ? -b : b;
                neg_q_reg <= a[31] ^ b[31];
                neg_r_reg <= a[31];
              end
`else
              state_reg   <= DONE;
              done        <= 1'b1;
              z_low       <= '0;
              z_high      <= '0;
              div_by_zero <= 1'b0;
`endif
            end
          end
        end
        MUL: begin
          prod_reg  <= prod_next;
          mcand_reg <= mcand_reg << 2;
          mplr_reg  <= {{2{mplr_reg[32]}}, mplr_reg[32:2]};
          cnt_reg   <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd15) begin
            state_reg   <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            z_low       <= prod_next[31:0];
            z_high      <= prod_next[63:32];
            div_by_zero <= 1'b0;
          end
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) begin
            state_reg   <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            z_low       <= q_out;
            z_high      <= r_out;
            div_by_zero <= 1'b0;
          end
        end
`endif
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit; divide expectations follow whether MULDIV_DIV_EN is defined.
// Latency N means done is visible N edges after the accepting edge (sampled by a consumer one edge later).
module tb_mul_div_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] z_low;
  logic [31:0] z_high;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .z_low(z_low), .z_high(z_high), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation, follow it to done, and check timing, hold and results.
  task automatic run_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y,
                        input int lat, input logic [31:0] e_lo, input logic [31:0] e_hi,
                        input logic e_dbz, input bit settle);
    logic [31:0] lo0, hi0;
    logic        d0;
    bit          early, changed;
    int          nbusy;
    lo0 = z_low; hi0 = z_high; d0 = div_by_zero;
    early = 0; changed = 0; nbusy = 0;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    for (int k = 0; k < lat; k++) begin
      if (done) early = 1;
      if (busy) nbusy++;
      if (z_low !== lo0 || z_high !== hi0 || div_by_zero !== d0) changed = 1;
      @(posedge clk); #1;
    end
    check({tag, " early_done"}, 64'(early), 64'd0);
    check({tag, " busy_cycles"}, 64'(nbusy), 64'(lat));
    check({tag, " held_midop"}, 64'(changed), 64'd0);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " result"}, {z_high, z_low}, {e_hi, e_lo});
    check({tag, " dbz"}, 64'(div_by_zero), 64'(e_dbz));
    $display("op %s: op=%0d a=%h b=%h -> z_high=%h z_low=%h dbz=%0d", tag, o, x, y, z_high, z_low, div_by_zero);
    if (settle) begin
      @(posedge clk); #1;
      check({tag, " done_pulse"}, 64'(done), 64'd0);
      check({tag, " result_hold"}, {z_high, z_low}, {e_hi, e_lo});
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {29'd0, busy, done, div_by_zero, z_high, z_low}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul_big",   1'b0, 32'h00FFFF22, 32'h00FFFF24, 16, 32'h4600BEC8, 32'h0000FFFE, 1'b0, 1);
    run_op("mul_neg",   1'b0, 32'hFFFFFFFA, 32'd7,        16, 32'hFFFFFFD6, 32'hFFFFFFFF, 1'b0, 1);
    run_op("mul_min",   1'b0, 32'h80000000, 32'h80000000, 16, 32'h00000000, 32'h40000000, 1'b0, 1);
    run_op("mul_mixed", 1'b0, 32'h7FFFFFFF, 32'h80000000, 16, 32'h80000000, 32'hC0000000, 1'b0, 0);
    // Chained from DONE: the next start is accepted without passing through IDLE.
    run_op("mul_m1m1",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16, 32'h00000001, 32'h00000000, 1'b0, 1);

    run_op("div_neg7",  1'b1, 32'hFFFFFFF9, 32'd2, DIV_EN ? 32 : 0,
           DIV_EN ? 32'hFFFFFFFD : 32'd0, DIV_EN ? 32'hFFFFFFFF : 32'd0, 1'b0, 1);
    run_op("div_zero",  1'b1, 32'd5, 32'd0, 0,
           DIV_EN ? 32'hFFFFFFFF : 32'd0, DIV_EN ? 32'd5 : 32'd0, DIV_EN, 1);
    // Flag and results from the divide-by-zero stay put while this multiply runs.
    run_op("mul_zero",  1'b0, 32'd0, 32'h12345678, 16, 32'd0, 32'd0, 1'b0, 1);
    run_op("div_ovf",   1'b1, 32'h80000000, 32'hFFFFFFFF, DIV_EN ? 32 : 0,
           DIV_EN ? 32'h80000000 : 32'd0, 32'd0, 1'b0, 1);
    run_op("div_pos",   1'b1, 32'd100, 32'd7, DIV_EN ? 32 : 0,
           DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 32'd2 : 32'd0, 1'b0, 1);
    run_op("div_mixed", 1'b1, 32'd7, 32'hFFFFFFFE, DIV_EN ? 32 : 0,
           DIV_EN ? 32'hFFFFFFFD : 32'd0, DIV_EN ? 32'd1 : 32'd0, 1'b0, 1);
    run_op("div_bothneg", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, DIV_EN ? 32 : 0,
           DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 32'hFFFFFFFE : 32'd0, 1'b0, 1);

    // A second start at cycle 5 of a multiply must be ignored.
    start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("ignore_done_early", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("ignore_done", 64'(done), 64'd1);
    check("ignore_result", {z_high, z_low}, 64'd99);
    $display("op ignore_start: 9*11 -> z_high=%h z_low=%h", z_high, z_low);
    @(posedge clk); #1;

    // Reset at cycle 8 of an operation, coinciding with a start: abort and no later done.
    start = 1'b1; op = DIV_EN; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1; start = 1'b1; op = 1'b0; a = 32'd6; b = 32'd6;
    @(posedge clk); #1;
    check("abort_outputs", {29'd0, busy, done, div_by_zero, z_high, z_low}, 64'd0);
    reset = 1'b0; start = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen = 1;
      @(posedge clk); #1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    $display("op abort: reset mid-operation, outputs cleared");
    run_op("mul_3x4", 1'b0, 32'd3, 32'd4, 16, 32'h0000000C, 32'd0, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
